b2bcd_seq_param: RTL and testbench

Parametrised iterative binary-to-BCD converter (shift-and-add-3 / double-dabble) with a start/done handshake. It is the successor to the fixed 8-bit/3-digit converters and is generic in input width and digit count. It serves as the shared conversion engine feeding the 7-segment display drivers, where operands wider than 8 bits are needed.

---
 rtl/b2bcd_seq_param.sv | 148 ++++++++++++++
 tb/tb_b2bcd_seq_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/b2bcd_seq_param.sv
// b2bcd_seq_param: iterative binary-to-BCD converter (shift-and-add-3) with start/done handshake.
// One shift per clock, BIN_W clocks per conversion, result held in bcd until the next done.
// Optional build macro B2BCD_SIGNED_EN: bin is two's complement, magnitude is converted and
// the sign is reported on the extra output neg.
module b2bcd_seq_param #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef B2BCD_SIGNED_EN
    ,
    output logic                  neg
`endif
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // 10**n as a 64-bit constant, used only for the elaboration-time range check
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Reject parameter sets whose digit count cannot hold the largest operand
    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
        $error("b2bcd_seq_param: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
        $error("b2bcd_seq_param: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_q,   bin_d;
    logic [SCR_W-1:0]     scr_q,   scr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [SCR_W-1:0]     bcd_q,   bcd_d;
    logic                 done_q,  done_d;

    logic [SCR_W-1:0]     scr_adj;
    logic [SCR_W-1:0]     scr_sh;
    logic [BIN_W-1:0]     bin_sh;
    logic [BIN_W-1:0]     bin_mag;

`ifdef B2BCD_SIGNED_EN
    logic                 sign_q, sign_d;
    logic                 neg_q,  neg_d;
    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude
    assign bin_mag = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
`else
    assign bin_mag = bin;
`endif

    // Add-3 correction on every digit >= 5, all digits in parallel on pre-shift values
    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? (scr_q[4*g +: 4] + 4'd3)
                                                              : scr_q[4*g +: 4];
    end

    // One-bit left shift of {scratch, operand}
    assign {scr_sh, bin_sh} = {scr_adj[SCR_W-2:0], bin_q, 1'b0};

    // Next-state, datapath and result-update logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
`ifdef B2BCD_SIGNED_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_mag;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
`ifdef B2BCD_SIGNED_EN
                    sign_d  = bin[BIN_W-1];
`endif
                end
            end
            SHIFT: begin
                bin_d = bin_sh;
                scr_d = scr_sh;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_sh;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef B2BCD_SIGNED_EN
                    neg_d   = sign_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
`ifdef B2BCD_SIGNED_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
`ifdef B2BCD_SIGNED_EN
            sign_q  <= sign_d;
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef B2BCD_SIGNED_EN
    assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_b2bcd_seq_param.sv
// Testbench for b2bcd_seq_param: 8-bit/3-digit and 16-bit/5-digit instances.
module tb_b2bcd_seq_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  bin8   = '0;
    logic        busy8, done8;
    logic [11:0] bcd8;
    logic        start16 = 1'b0;
    logic [15:0] bin16   = '0;
    logic        busy16, done16;
    logic [19:0] bcd16;
    logic        neg8, neg16;

    b2bcd_seq_param #(.BIN_W(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8)
`ifdef B2BCD_SIGNED_EN
        , .neg(neg8)
`endif
    );

    b2bcd_seq_param #(.BIN_W(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16)
`ifdef B2BCD_SIGNED_EN
        , .neg(neg16)
`endif
    );

`ifndef B2BCD_SIGNED_EN
    assign neg8  = 1'b0;
    assign neg16 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wide;
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        neg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference conversion by repeated division (independent of shift-and-add-3)
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // One full conversion on the selected instance with latency/busy/done checks
    task automatic conv(input logic wide, input logic [15:0] v, input logic [19:0] exp,
                        input logic expneg, input string name);
        int k;
        int n;
        n = wide ? 16 : 8;
        if (wide) begin start16 = 1'b1; bin16 = v; end
        else      begin start8  = 1'b1; bin8  = v[7:0]; end
        step();
        start8  = 1'b0;
        start16 = 1'b0;
        bin8    = 8'h5A;
        bin16   = 16'hA5A5;
        chk({name, " busy_after_accept"}, wide ? busy16 : busy8, 32'd1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (wide ? done16 : done8) begin k = i; break; end
        end
        chk({name, " latency"}, k, n);
        chk({name, " bcd"}, wide ? bcd16 : {8'h0, bcd8}, exp);
        chk({name, " busy_at_done"}, wide ? busy16 : busy8, 32'd0);
`ifdef B2BCD_SIGNED_EN
        chk({name, " neg"}, wide ? neg16 : neg8, expneg);
`endif
        step();
        chk({name, " done_one_cycle"}, wide ? done16 : done8, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, ndone;
        logic [19:0] e;
        logic        en;

`ifdef B2BCD_SIGNED_EN
        tbl.push_back('{1'b0, 16'h0080, 20'h00128, 1'b1});
        tbl.push_back('{1'b0, 16'h00FF, 20'h00001, 1'b1});
        tbl.push_back('{1'b0, 16'h007F, 20'h00127, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 20'h00000, 1'b0});
        tbl.push_back('{1'b0, 16'h009C, 20'h00100, 1'b1});
        tbl.push_back('{1'b1, 16'h8000, 20'h32768, 1'b1});
        tbl.push_back('{1'b1, 16'hFFFF, 20'h00001, 1'b1});
        tbl.push_back('{1'b1, 16'd1000, 20'h01000, 1'b0});
        tbl.push_back('{1'b1, 16'h7FFF, 20'h32767, 1'b0});
`else
        tbl.push_back('{1'b0, 16'd255,   20'h00255, 1'b0});
        tbl.push_back('{1'b0, 16'd0,     20'h00000, 1'b0});
        tbl.push_back('{1'b0, 16'd1,     20'h00001, 1'b0});
        tbl.push_back('{1'b0, 16'd9,     20'h00009, 1'b0});
        tbl.push_back('{1'b0, 16'd10,    20'h00010, 1'b0});
        tbl.push_back('{1'b0, 16'd99,    20'h00099, 1'b0});
        tbl.push_back('{1'b0, 16'd100,   20'h00100, 1'b0});
        tbl.push_back('{1'b0, 16'd128,   20'h00128, 1'b0});
        tbl.push_back('{1'b1, 16'd65535, 20'h65535, 1'b0});
        tbl.push_back('{1'b1, 16'd1000,  20'h01000, 1'b0});
        tbl.push_back('{1'b1, 16'd0,     20'h00000, 1'b0});
        tbl.push_back('{1'b1, 16'd12345, 20'h12345, 1'b0});
        tbl.push_back('{1'b1, 16'd9999,  20'h09999, 1'b0});
`endif

        // Reset state
        #12;
        chk("rst busy8", busy8, 0);
        chk("rst done8", done8, 0);
        chk("rst bcd8", bcd8, 0);
        chk("rst busy16", busy16, 0);
        chk("rst bcd16", bcd16, 0);
        chk("rst neg8", neg8, 0);
        step();
        rst = 1'b0;
        step();

        // Directed vector table
        foreach (tbl[i])
            conv(tbl[i].wide, tbl[i].bin, tbl[i].bcd, tbl[i].neg, $sformatf("vec%0d", i));

        // Full 8-bit sweep with start held high: done every 9 cycles
        bin8   = 8'd0;
        start8 = 1'b1;
        step();
        for (int v = 0; v < 256; v++) begin
            k = 0;
            for (int i = 1; i <= 20; i++) begin
                step();
                if (done8) begin k = i; break; end
            end
`ifdef B2BCD_SIGNED_EN
            en = (v >= 128);
            e  = ref_bcd(en ? 256 - v : v);
            chk($sformatf("sweep%0d neg", v), neg8, en);
`else
            e  = ref_bcd(v);
`endif
            chk($sformatf("sweep%0d spacing", v), k, (v == 0) ? 8 : 9);
            chk($sformatf("sweep%0d bcd", v), {8'h0, bcd8}, e);
            if (v == 255) start8 = 1'b0;
            else          bin8   = 8'(v + 1);
        end
        step();

        // start while busy is ignored
        bin8 = 8'd200; start8 = 1'b1;
        step();
        start8 = 1'b0; bin8 = 8'd0;
        step();
        step();
        start8 = 1'b1; bin8 = 8'd17;
        step();
        start8 = 1'b0; bin8 = 8'd0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done8) begin k = i; break; end
        end
        chk("ignore latency", k, 5);
`ifdef B2BCD_SIGNED_EN
        chk("ignore bcd", bcd8, 12'h056);
        chk("ignore neg", neg8, 1);
`else
        chk("ignore bcd", bcd8, 12'h200);
`endif
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done8) ndone++;
        end
        chk("ignore no_second_done", ndone, 0);

        // Asynchronous reset mid-conversion
        bin8 = 8'd99; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        #3 rst = 1'b1;
        #1;
        chk("midrst busy", busy8, 0);
        chk("midrst bcd", bcd8, 0);
        chk("midrst done", done8, 0);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done8) ndone++;
        end
        chk("midrst no_done", ndone, 0);
        conv(1'b0, 16'd42, 20'h00042, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
